// File: rtl/uart_pkg.sv
// Shared types and default parameter values for the UART blocks.
// Both the FIFO-fed transmitter and the future receiver pull these in.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam int UART_CLK_DIV_DEFAULT   = 868;
    localparam int UART_DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the terminal count.
// The count clears by itself on the tick and whenever clr is high.
module uart_baud_cnt #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each as a UART
// frame on tx, streaming frames back-to-back while data is available.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT,
    parameter int CLK_DIV   = UART_CLK_DIV_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 rd,
    output logic                 tx,
    output logic                 busy
);

    localparam int               BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t       state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 tx_reg, tx_next;
    logic                 armed_reg;

    logic baud_tick;
    logic pop;
    logic last_bit;
    logic last_stop;
    logic frame_done;

    // Hold the counter at zero in IDLE so START always gets a full bit period.
    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == IDLE),
        .tick  (baud_tick)
    );

    // armed_reg keeps rd quiet between reset release and the first clock edge.
    assign pop        = armed_reg & tx_en & ~empty;
    assign last_bit   = (bit_cnt_reg == LAST_BIT);
    assign last_stop  = (STOP_BITS == 1) | stop_cnt_reg;
    assign frame_done = (state_reg == STOP) & baud_tick & last_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            tx_reg       <= tx_next;
            armed_reg    <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = START;
                    shift_next = r_data;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (last_bit) begin
                        state_next    = STOP;
                        stop_cnt_next = 1'b0;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (!last_stop) begin
                        stop_cnt_next = 1'b1;
                    end else if (pop) begin
                        state_next = START;
                        shift_next = r_data;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge as the state it represents.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        rd   = pop & ((state_reg == IDLE) | frame_done);
        busy = (state_reg != IDLE);
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLK_DIV=4: frame table plus
// hand-written reset, gating, underrun and two-stop-bit sequences.
module tb_fifo_uart_tx;

    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic tx_en  = 1'b0;

    logic       empty1, empty2;
    logic [7:0] r_data1, r_data2;
    logic       rd1, rd2, tx1, tx2, busy1, busy2;

    logic [7:0] mem1 [0:31];
    logic [7:0] mem2 [0:31];
    logic [4:0] wr1   = '0;
    logic [4:0] wr2   = '0;
    logic [4:0] rd_p1 = '0;
    logic [4:0] rd_p2 = '0;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] data;
        logic       chain;
        logic [9:0] frame;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    // Behavioural first-word-fall-through FIFOs, one per DUT.
    assign empty1  = (wr1 == rd_p1);
    assign empty2  = (wr2 == rd_p2);
    assign r_data1 = mem1[rd_p1];
    assign r_data2 = mem2[rd_p2];

    always @(posedge clk) begin
        if (rd1) rd_p1 <= rd_p1 + 5'd1;
        if (rd2) rd_p2 <= rd_p2 + 5'd1;
    end

    fifo_uart_tx #(
        .DATA_BITS (DATA_BITS),
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_en  (tx_en),
        .empty  (empty1),
        .r_data (r_data1),
        .rd     (rd1),
        .tx     (tx1),
        .busy   (busy1)
    );

    fifo_uart_tx #(
        .DATA_BITS (DATA_BITS),
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (2)
    ) dut2 (
        .clk    (clk),
        .reset  (reset),
        .tx_en  (tx_en),
        .empty  (empty2),
        .r_data (r_data2),
        .rd     (rd2),
        .tx     (tx2),
        .busy   (busy2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1] = b;
        wr1 = wr1 + 5'd1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2] = b;
        wr2 = wr2 + 5'd1;
    endtask

    task automatic wait_rd(input string name, input int sel);
        logic seen;
        seen = 1'b0;
        #1;
        for (int k = 0; k < 200 && !seen; k++) begin
            if ((sel == 2) ? rd2 : rd1) seen = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_pop"}, 64'(seen), 64'd1);
    endtask

    task automatic idle_check(input string name, input int sel);
        @(negedge clk);
        chk({name, "_busy"}, 64'((sel == 2) ? busy2 : busy1), 64'd0);
        chk({name, "_tx"},   64'((sel == 2) ? tx2 : tx1),     64'd1);
    endtask

    // Call in the pop cycle; samples every clock of the frame that follows.
    task automatic run_frame(input string name, input int sel, input int nbits,
                             input logic [10:0] frame, input logic exp_rd_end,
                             input int drop_at);
        logic [47:0] obs, exp;
        int          rd_early;
        logic        rd_last, busy_low, t, r, b;
        obs = '0; exp = '0; rd_early = 0; rd_last = 1'b0; busy_low = 1'b0;
        for (int j = 0; j < nbits * CLK_DIV; j++) begin
            @(negedge clk);
            t = (sel == 2) ? tx2 : tx1;
            r = (sel == 2) ? rd2 : rd1;
            b = (sel == 2) ? busy2 : busy1;
            obs[j] = t;
            exp[j] = frame[j / CLK_DIV];
            if (!b) busy_low = 1'b1;
            if (j == nbits * CLK_DIV - 1) rd_last = r;
            else if (r) rd_early++;
            if (j == drop_at) tx_en = 1'b0;
        end
        chk({name, "_bits"},     64'(obs),      64'(exp));
        chk({name, "_rd_early"}, 64'(rd_early), 64'd0);
        chk({name, "_rd_end"},   64'(rd_last),  64'(exp_rd_end));
        chk({name, "_busy"},     64'(busy_low), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        logic nxt_chain;

        tbl[0] = '{8'hA5, 1'b0, 10'b1_10100101_0};
        tbl[1] = '{8'h00, 1'b0, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 1'b1, 10'b1_11111111_0};
        tbl[3] = '{8'h3C, 1'b1, 10'b1_00111100_0};
        tbl[4] = '{8'h81, 1'b0, 10'b1_10000001_0};

        // Reset held with data waiting and tx enabled.
        tx_en = 1'b1;
        push1(8'h5A);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || rd1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
        end
        chk("reset_hold", 64'(bad), 64'd0);
        reset = 1'b1;
        #1;
        chk("rd_before_edge", 64'(rd1), 64'd0);
        @(negedge clk);
        chk("rd_first_cycle", 64'(rd1), 64'd1);
        run_frame("frame_5a", 1, 10, 11'(10'b1_01011010_0), 1'b0, -1);
        idle_check("frame_5a_idle", 1);

        // Frame table: chained entries follow the previous one back-to-back.
        for (int i = 0; i < 5; i++) begin
            if (!tbl[i].chain) begin
                push1(tbl[i].data);
                wait_rd($sformatf("vec%0d", i), 1);
            end
            nxt_chain = (i + 1 < 5) ? tbl[i + 1].chain : 1'b0;
            if (nxt_chain) push1(tbl[i + 1].data);
            run_frame($sformatf("vec%0d", i), 1, 10, 11'(tbl[i].frame), nxt_chain, -1);
            $display("vec%0d data=%02h chain=%0d done", i, tbl[i].data, tbl[i].chain);
            if (!nxt_chain) idle_check($sformatf("vec%0d_idle", i), 1);
        end

        // Underrun: enabled with an empty FIFO.
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (rd1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
        end
        chk("underrun", 64'(bad), 64'd0);

        // Enable dropped mid-frame with more data queued.
        tx_en = 1'b0;
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        @(negedge clk);
        tx_en = 1'b1;
        wait_rd("gate_first", 1);
        run_frame("gate_11", 1, 10, 11'(10'b1_00010001_0), 1'b0, 20);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rd1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
        end
        chk("gate_hold", 64'(bad), 64'd0);
        tx_en = 1'b1;
        wait_rd("gate_resume", 1);
        run_frame("gate_22", 1, 10, 11'(10'b1_00100010_0), 1'b1, -1);
        run_frame("gate_33", 1, 10, 11'(10'b1_00110011_0), 1'b0, -1);
        idle_check("gate_idle", 1);

        // Reset asserted in the middle of a data bit.
        push1(8'h00);
        wait_rd("mreset", 1);
        repeat (12) @(negedge clk);
        chk("mreset_tx_low", 64'(tx1),   64'd0);
        chk("mreset_busy",   64'(busy1), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mreset_tx_high", 64'(tx1),   64'd1);
        chk("mreset_idle",    64'(busy1), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (rd1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
        end
        chk("mreset_no_resend", 64'(bad), 64'd0);

        // Two stop bits: 11 bit periods, last two high.
        push2(8'h55);
        wait_rd("s2", 2);
        run_frame("s2_frame", 2, 11, 11'b11_01010101_0, 1'b0, -1);
        idle_check("s2_idle", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
